multiword_add_ctrl: RTL

//  Sequencer that reuses one combinational WORD_SIZE-bit ripple adder to add two
//  NUM_WORDS*WORD_SIZE-bit operands, one word per cycle, LSW first. Carry-out of

---
 rtl/multiword_add_ctrl_if.sv | 45 ++++
 rtl/multiword_add_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/multiword_add_ctrl_if.sv
// multiword_add_ctrl_if: operand/result handshake and shared-adder bus for multiword_add_ctrl
//   in_valid/in_ready/op_a/op_b/cin : operand producer side (plus sub when MULTIWORD_ADD_SUB_EN)
//   add_a/add_b/add_cin/add_sum/add_cout : external WORD_SIZE-bit adder
//   out_valid/out_ready/result/cout : result consumer side
//   slave modport = controller, master modport = surrounding environment
interface multiword_add_ctrl_if #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_WORDS = 4
);
    localparam int W = WORD_SIZE * NUM_WORDS;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic                 cin;
    logic [WORD_SIZE-1:0] add_a;
    logic [WORD_SIZE-1:0] add_b;
    logic                 add_cin;
    logic [WORD_SIZE-1:0] add_sum;
    logic                 add_cout;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         result;
    logic                 cout;
`ifdef MULTIWORD_ADD_SUB_EN
    logic                 sub;
    modport slave (
        input  in_valid, op_a, op_b, cin, sub, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, result, cout
    );
    modport master (
        output in_valid, op_a, op_b, cin, sub, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, result, cout
    );
`else
    modport slave (
        input  in_valid, op_a, op_b, cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, result, cout
    );
    modport master (
        output in_valid, op_a, op_b, cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, result, cout
    );
`endif
endinterface

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: sequences one shared WORD_SIZE-bit adder over NUM_WORDS words, LSW first
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : multiword_add_ctrl_if.slave (operand handshake, adder drive/sample, result handshake)
//   MULTIWORD_ADD_SUB_EN : when defined, bus.sub selects op_a - op_b (two's complement)
module multiword_add_ctrl #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_WORDS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    multiword_add_ctrl_if.slave bus
);
    localparam int W  = WORD_SIZE * NUM_WORDS;
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic          run;
    logic          accept;
    logic          sub_in;
`ifdef MULTIWORD_ADD_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif
    assign run           = state_q == RUN;
    assign bus.in_ready  = rst_n && state_q == IDLE;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.add_a     = run ? a_q[idx_q*WORD_SIZE +: WORD_SIZE] : '0;
    assign bus.add_b     = run ? b_q[idx_q*WORD_SIZE +: WORD_SIZE] : '0;
    assign bus.add_cin   = run && carry_q;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    // Subtraction stores ~op_b and forces the initial carry, so RUN is identical for both modes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (accept) begin
                a_d     = bus.op_a;
                b_d     = sub_in ? ~bus.op_b : bus.op_b;
                carry_d = sub_in || bus.cin;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                result_d[idx_q*WORD_SIZE +: WORD_SIZE] = bus.add_sum;
                carry_d = bus.add_cout;
                if (idx_q == IW'(NUM_WORDS - 1)) begin
                    cout_d  = bus.add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end
endmodule
